pipe_perf_monitor: RTL and testbench

Parametrised performance-event monitor for the pipelined CPU. It counts run cycles and up to NUM_EVT per-cycle pipeline events, such as hazard-unit stalls, flushes and branches taken. It halts at a configurable cycle budget and exposes atomic snapshots through a registered read port. It sits beside the CPU top, is fed by hazard/control strobes, and replaces ad-hoc bench-side stall/flush tallies with synthesizable counters.

---
 rtl/pipe_perf_monitor.sv | 111 +++++++++++
 tb/tb_pipe_perf_monitor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_perf_monitor.sv
// Performance-event monitor: counts run cycles and per-cycle pipeline events,
// halts at a cycle budget and serves atomic snapshots through a registered read port.
module pipe_perf_monitor #(
  parameter  int NUM_EVT     = 2,
  parameter  int CNT_W       = 32,
  parameter  int HALT_CYCLES = 30,
  parameter  int SATURATE    = 0,
  localparam int SEL_W       = $clog2(NUM_EVT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               clear_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               snap_valid_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic               running_o,
  output logic               halt_o
);

  localparam int NUM_CNT = NUM_EVT + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt [NUM_CNT];
  logic [CNT_W-1:0]   r_shd [NUM_CNT];
  logic [NUM_CNT-1:0] r_ovf;
  logic [CNT_W-1:0]   r_rd_data;
  logic               r_snap_valid;

  logic               w_run;
  logic               w_hit;
  logic [NUM_CNT-1:0] w_inc;
  logic [NUM_CNT-1:0] w_max;
  logic [CNT_W-1:0]   w_nxt [NUM_CNT];

  assign w_run = (r_state == S_RUN);

  // Slot 0 is the cycle counter; slot k+1 tracks event k.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_inc = {evt_i & {NUM_EVT{w_run}}, w_run};
    w_max = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      w_nxt[i] = r_cnt[i];
      w_max[i] = (r_cnt[i] == '1);
      if (w_inc[i] && !(w_max[i] && SATURATE != 0))
        w_nxt[i] = r_cnt[i] + CNT_W'(1);
    end
  end

  assign w_hit = w_run && (HALT_CYCLES != 0) && (w_nxt[0] == CNT_W'(HALT_CYCLES));

  // NOTE: sequential state uses non-blocking assignments only, so every reader
  //       (shadow capture, read port) sees the values registered before this edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_ovf        <= '0;
      r_rd_data    <= '0;
      r_snap_valid <= 1'b0;
      // NOTE: the shadow bank is a handful of flops, not RAM, so it is reset explicitly.
      for (int i = 0; i < NUM_CNT; i++) begin
        r_cnt[i] <= '0;
        r_shd[i] <= '0;
      end
    end else begin
      r_snap_valid <= snap_i;
      if (snap_i) begin
        for (int i = 0; i < NUM_CNT; i++) r_shd[i] <= r_cnt[i];
      end

      if (rd_sel_i <= SEL_W'(NUM_EVT)) r_rd_data <= r_shd[rd_sel_i];
      else                             r_rd_data <= '0;

      if (clear_i) begin
        r_state <= S_IDLE;
        r_ovf   <= '0;
        for (int i = 0; i < NUM_CNT; i++) r_cnt[i] <= '0;
      end else begin
        r_ovf <= r_ovf | (w_inc & w_max);
        for (int i = 0; i < NUM_CNT; i++) r_cnt[i] <= w_nxt[i];
        unique case (r_state)
          S_IDLE: if (start_i) r_state <= S_RUN;
          S_RUN: begin
            // Reaching the budget wins over a same-cycle pause request.
            if (w_hit)         r_state <= S_HALT;
            else if (!start_i) r_state <= S_IDLE;
          end
          S_HALT:  r_state <= S_HALT;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_data_o    = r_rd_data;
  assign snap_valid_o = r_snap_valid;
  assign ovf_o        = r_ovf;
  assign running_o    = (r_state == S_RUN);
  assign halt_o       = (r_state == S_HALT);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: three instances (budget, wrap, saturate)
// share one stimulus stream; expected values are hand-computed constants.
module tb_pipe_perf_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       snap = 1'b0;
  logic [1:0] evt = 2'b00;
  logic [1:0] sel = 2'd0;

  logic [7:0] rd_b;
  logic [3:0] rd_w, rd_s;
  logic       sv_b, sv_w, sv_s;
  logic [2:0] ovf_b, ovf_w, ovf_s;
  logic       run_b, run_w, run_s;
  logic       halt_b, halt_w, halt_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_perf_monitor #(.NUM_EVT(2), .CNT_W(8), .HALT_CYCLES(30), .SATURATE(0)) u_bud (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .clear_i(clear),
    .snap_i(snap), .rd_sel_i(sel), .rd_data_o(rd_b), .snap_valid_o(sv_b),
    .ovf_o(ovf_b), .running_o(run_b), .halt_o(halt_b));

  pipe_perf_monitor #(.NUM_EVT(2), .CNT_W(4), .HALT_CYCLES(0), .SATURATE(0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .clear_i(clear),
    .snap_i(snap), .rd_sel_i(sel), .rd_data_o(rd_w), .snap_valid_o(sv_w),
    .ovf_o(ovf_w), .running_o(run_w), .halt_o(halt_w));

  pipe_perf_monitor #(.NUM_EVT(2), .CNT_W(4), .HALT_CYCLES(0), .SATURATE(1)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .clear_i(clear),
    .snap_i(snap), .rd_sel_i(sel), .rd_data_o(rd_s), .snap_valid_o(sv_s),
    .ovf_o(ovf_s), .running_o(run_s), .halt_o(halt_s));

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_rd",      64'(rd_b),   64'd0);
    check("rst_sv",      64'(sv_b),   64'd0);
    check("rst_ovf",     64'(ovf_b),  64'd0);
    check("rst_running", 64'(run_b),  64'd0);
    check("rst_halt",    64'(halt_b), 64'd0);

    // Budget run: the IDLE->RUN edge is not counted, then 30 counted cycles
    start = 1'b1;
    tick();
    check("bud_running", 64'(run_b), 64'd1);
    for (int c = 1; c <= 30; c++) begin
      evt[0] = (c >= 3 && c <= 7);
      evt[1] = (c == 10 || c == 11);
      tick();
      if (c == 29) check("bud_not_yet_halt", 64'(halt_b), 64'd0);
    end
    check("bud_halt",     64'(halt_b), 64'd1);
    check("bud_not_run",  64'(run_b),  64'd0);
    evt = 2'b11;
    repeat (3) tick();
    check("bud_halt_ignores_start", 64'(halt_b), 64'd1);
    evt  = 2'b00;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    check("bud_snap_valid", 64'(sv_b), 64'd1);
    sel = 2'd0;
    tick();
    check("bud_snap_valid_once", 64'(sv_b), 64'd0);
    check("bud_cycles", 64'(rd_b), 64'd30);
    sel = 2'd1;
    tick();
    check("bud_evt0", 64'(rd_b), 64'd5);
    sel = 2'd2;
    tick();
    check("bud_evt1", 64'(rd_b), 64'd2);

    // Simultaneous clear/snap/event with counters at 7
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_leaves_halt", 64'(halt_b), 64'd0);
    check("clr_idle",        64'(run_b),  64'd0);
    tick();
    check("clr_to_run", 64'(run_b), 64'd1);
    evt = 2'b01;
    repeat (7) tick();
    clear = 1'b1;
    snap  = 1'b1;
    tick();
    clear = 1'b0;
    snap  = 1'b0;
    evt   = 2'b00;
    start = 1'b0;
    check("combo_idle", 64'(run_b), 64'd0);
    check("combo_sv",   64'(sv_b),  64'd1);
    sel = 2'd1;
    tick();
    check("combo_sv_once",  64'(sv_b), 64'd0);
    check("combo_shd_evt0", 64'(rd_b), 64'd7);
    sel = 2'd0;
    tick();
    check("combo_shd_cyc", 64'(rd_b), 64'd7);
    sel  = 2'd1;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    check("same_cycle_read_old", 64'(rd_b), 64'd7);
    tick();
    check("live_cleared", 64'(rd_b), 64'd0);

    // Pause/resume with evt[0] high throughout
    evt   = 2'b01;
    start = 1'b1;
    tick();
    repeat (3) tick();
    start = 1'b0;
    repeat (4) tick();
    check("pause_idle", 64'(run_b), 64'd0);
    start = 1'b1;
    tick();
    check("resume_run", 64'(run_b), 64'd1);
    repeat (2) tick();
    start = 1'b0;
    snap  = 1'b1;
    tick();
    snap = 1'b0;
    evt  = 2'b00;
    sel  = 2'd0;
    tick();
    check("pause_cyc", 64'(rd_b), 64'd6);
    sel = 2'd1;
    tick();
    check("pause_evt0", 64'(rd_b), 64'd6);
    sel = 2'd2;
    tick();
    check("pause_evt1", 64'(rd_b), 64'd0);

    // Wrap / saturate: exactly 17 counted cycles with evt[0] high
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b1;
    tick();
    evt = 2'b01;
    for (int c = 1; c <= 17; c++) begin
      if (c == 17) start = 1'b0;
      tick();
    end
    evt = 2'b00;
    check("wrap_ovf", 64'(ovf_w), 64'b011);
    check("sat_ovf",  64'(ovf_s), 64'b011);
    check("bud_ovf",  64'(ovf_b), 64'b000);
    check("wrap_idle", 64'(run_w), 64'd0);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    sel  = 2'd0;
    tick();
    check("wrap_cyc", 64'(rd_w), 64'd1);
    check("sat_cyc",  64'(rd_s), 64'd15);
    check("bud17_cyc", 64'(rd_b), 64'd17);
    sel = 2'd1;
    tick();
    check("wrap_evt0", 64'(rd_w), 64'd1);
    check("sat_evt0",  64'(rd_s), 64'd15);
    check("bud17_evt0", 64'(rd_b), 64'd17);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("wrap_ovf_cleared", 64'(ovf_w), 64'b000);
    check("sat_ovf_cleared",  64'(ovf_s), 64'b000);
    tick();
    check("clear_keeps_shadow", 64'(rd_s), 64'd15);

    // Out-of-range read with a populated shadow bank, then reset mid-RUN
    start = 1'b1;
    evt   = 2'b11;
    tick();
    repeat (3) tick();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    sel  = 2'd3;
    tick();
    check("oob_read", 64'(rd_b), 64'd0);
    check("pre_rst_running", 64'(run_b), 64'd1);
    sel  = 2'd1;
    tick();
    check("pre_rst_evt0", 64'(rd_b), 64'd3);
    rst  = 1'b1;
    snap = 1'b1;
    tick();
    rst   = 1'b0;
    snap  = 1'b0;
    start = 1'b0;
    evt   = 2'b00;
    check("mid_rst_running", 64'(run_b), 64'd0);
    check("mid_rst_halt",    64'(halt_b), 64'd0);
    check("mid_rst_sv",      64'(sv_b),  64'd0);
    check("mid_rst_ovf",     64'(ovf_w), 64'd0);
    check("mid_rst_rd",      64'(rd_b),  64'd0);
    tick();
    check("mid_rst_shadow", 64'(rd_b), 64'd0);
    sel = 2'd3;
    tick();
    check("mid_rst_oob", 64'(rd_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
